titan_if_bus: RTL and testbench



---
 rtl/titan_if_bus_pkg.sv | 16 +
 rtl/titan_bus_watchdog.sv | 31 +++
 rtl/titan_if_bus.sv | 128 ++++++++++++
 tb/tb_titan_if_bus.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/titan_if_bus_pkg.sv
// Shared definitions for the Titan instruction-fetch bus master:
// FSM state encoding, default NOP word and Wishbone select constant.
package titan_if_bus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } if_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstDefault = 32'h0000_0013;
  localparam logic [3:0]  WbSelAll       = 4'b1111;

endpackage

// File: rtl/titan_bus_watchdog.sv
// Per-request bus watchdog: counts BUSY/DRAIN cycles and flags the
// TIMEOUT-th cycle without termination. TIMEOUT=0 disables it.
module titan_bus_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CntW-1:0] r_count;
  logic            w_expired;

  // Count holds the number of completed waiting cycles, so the current cycle is r_count+1.
  assign w_expired = (TIMEOUT != 0) && enable_i && (r_count == LastCnt);
  assign expired_o = w_expired;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_count <= '0;
    end else if (enable_i && !w_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/titan_if_bus.sv
// Instruction-fetch Wishbone classic master: one read per instruction,
// with squash/drain on redirect and an IF stall while a fetch is pending.
module titan_if_bus
  import titan_if_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = NopInstDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  input  logic        if_hold_i,
  input  logic        if_kill_i,
  output logic [31:0] if_instruction_o,
  output logic        if_bus_access_fault_o,
  output logic        if_stall_o,
  output logic [31:0] iwbm_addr_o,
  output logic [3:0]  iwbm_sel_o,
  output logic        iwbm_we_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i
);

  if_state_e   r_state, w_state_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_inst, w_inst_d;
  logic        r_fault, w_fault_d;
  logic        r_cyc;
  logic        w_wd_clear, w_wd_enable, w_expired, w_term;

  titan_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_wd_clear),
    .enable_i (w_wd_enable),
    .expired_o(w_expired)
  );

  assign w_term = iwbm_ack_i || iwbm_err_i || w_expired;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_inst_d    = r_inst;
    w_fault_d   = r_fault;
    w_wd_clear  = 1'b0;
    w_wd_enable = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!if_kill_i) begin
          if (if_pc_i[1:0] != 2'b00) begin
            // Misalignment is reported downstream; no bus access here.
            w_state_d = StDone;
            w_inst_d  = NOP_INST;
            w_fault_d = 1'b0;
          end else begin
            w_addr_d   = if_pc_i;
            w_wd_clear = 1'b1;
            w_state_d  = StBusy;
          end
        end
      end
      StBusy: begin
        w_wd_enable = 1'b1;
        if (w_term) begin
          if (if_kill_i) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StDone;
            // err beats ack; no ack and no err means the watchdog fired.
            if (iwbm_err_i || !iwbm_ack_i) begin
              w_inst_d  = NOP_INST;
              w_fault_d = 1'b1;
            end else begin
              w_inst_d  = iwbm_dat_i;
              w_fault_d = 1'b0;
            end
          end
        end else if (if_kill_i) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        w_wd_enable = 1'b1;
        if (w_term) begin
          w_state_d = StIdle;
        end
      end
      StDone: begin
        if (if_kill_i || !if_hold_i) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_inst  <= NOP_INST;
      r_fault <= 1'b0;
      r_cyc   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_inst  <= w_inst_d;
      r_fault <= w_fault_d;
      r_cyc   <= (w_state_d == StBusy) || (w_state_d == StDrain);
    end
  end

  assign if_instruction_o      = r_inst;
  assign if_bus_access_fault_o = r_fault;
  assign if_stall_o            = (r_state != StDone);
  assign iwbm_addr_o           = r_addr;
  assign iwbm_sel_o            = WbSelAll;
  assign iwbm_we_o             = 1'b0;
  assign iwbm_cyc_o            = r_cyc;
  assign iwbm_stb_o            = r_cyc;

endmodule

// File: tb/tb_titan_if_bus.sv
// Bench for titan_if_bus: directed scenarios plus randomized fetches checked
// against a transaction-level latency/result model.
module tb_titan_if_bus;

  localparam int unsigned T   = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc_i;
  logic        if_hold_i, if_kill_i;
  logic [31:0] if_instruction_o;
  logic        if_bus_access_fault_o, if_stall_o;
  logic [31:0] iwbm_addr_o;
  logic [3:0]  iwbm_sel_o;
  logic        iwbm_we_o, iwbm_cyc_o, iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i, iwbm_err_i;

  always #5 clk = ~clk;

  titan_if_bus #(
    .TIMEOUT (T),
    .NOP_INST(NOP)
  ) u_dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .if_pc_i              (if_pc_i),
    .if_hold_i            (if_hold_i),
    .if_kill_i            (if_kill_i),
    .if_instruction_o     (if_instruction_o),
    .if_bus_access_fault_o(if_bus_access_fault_o),
    .if_stall_o           (if_stall_o),
    .iwbm_addr_o          (iwbm_addr_o),
    .iwbm_sel_o           (iwbm_sel_o),
    .iwbm_we_o            (iwbm_we_o),
    .iwbm_cyc_o           (iwbm_cyc_o),
    .iwbm_stb_o           (iwbm_stb_o),
    .iwbm_dat_i           (iwbm_dat_i),
    .iwbm_ack_i           (iwbm_ack_i),
    .iwbm_err_i           (iwbm_err_i)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] last_inst;
  logic        last_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int busy_len(input int waits);
    return (waits + 1 < int'(T)) ? waits + 1 : int'(T);
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic fetch(input logic [31:0] pc, input int waits, input bit use_err,
                       input bit both, input logic [31:0] data, input int hold,
                       input bit kill_in_hold);
    int n, busy_n, exp_lat, exp_busy;
    bit done;
    logic [31:0] exp_inst;
    logic exp_fault;
    if (pc[1:0] != 2'b00) begin
      exp_busy = 0; exp_inst = NOP; exp_fault = 1'b0;
    end else begin
      exp_busy = busy_len(waits);
      if (waits + 1 > int'(T) || use_err || both) begin
        exp_inst = NOP; exp_fault = 1'b1;
      end else begin
        exp_inst = data; exp_fault = 1'b0;
      end
    end
    exp_lat = 1 + exp_busy;
    if_pc_i = pc; if_hold_i = 1'b0; if_kill_i = 1'b0;
    iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0;
    n = 0; busy_n = 0; done = 1'b0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0; iwbm_dat_i = $urandom;
      if (if_stall_o === 1'b0) begin
        done = 1'b1;
      end else if (iwbm_cyc_o === 1'b1) begin
        busy_n++;
        check_eq("busy_addr", iwbm_addr_o, pc);
        if (busy_n == waits + 1) begin
          iwbm_ack_i = !use_err || both;
          iwbm_err_i = use_err || both;
          iwbm_dat_i = data;
        end
      end
    end
    check_eq("latency", n, exp_lat);
    check_eq("busy_cycles", busy_n, exp_busy);
    check_eq("inst", if_instruction_o, exp_inst);
    check_eq("fault", {31'b0, if_bus_access_fault_o}, {31'b0, exp_fault});
    for (int h = 0; h < hold; h++) begin
      if_hold_i  = 1'b1;
      iwbm_ack_i = 1'($urandom_range(0, 1));
      iwbm_dat_i = $urandom;
      @(negedge clk);
      check_eq("hold_stall", {31'b0, if_stall_o}, 32'd0);
      check_eq("hold_cyc", {31'b0, iwbm_cyc_o}, 32'd0);
      check_eq("hold_inst", if_instruction_o, exp_inst);
    end
    iwbm_ack_i = 1'b0;
    if_hold_i  = kill_in_hold;
    if_kill_i  = kill_in_hold;
    @(negedge clk);
    if_hold_i = 1'b0; if_kill_i = 1'b0;
    check_eq("leave_done_stall", {31'b0, if_stall_o}, 32'd1);
    check_eq("leave_done_cyc", {31'b0, iwbm_cyc_o}, 32'd0);
    last_inst = exp_inst; last_fault = exp_fault;
  endtask

  // Redirect during BUSY: the word must never surface and the bus must still terminate.
  task automatic kill_fetch(input logic [31:0] pc, input int waits, input int kill_at,
                            input logic [31:0] data);
    int n, busy_n;
    bit done;
    if_pc_i = pc; if_hold_i = 1'b0; if_kill_i = 1'b0;
    n = 0; busy_n = 0; done = 1'b0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0; if_kill_i = 1'b0; iwbm_dat_i = $urandom;
      if (busy_n > 0 && iwbm_cyc_o !== 1'b1) begin
        done = 1'b1;
      end else if (iwbm_cyc_o === 1'b1) begin
        busy_n++;
        check_eq("kill_addr", iwbm_addr_o, pc);
        if (busy_n == waits + 1) begin
          iwbm_ack_i = 1'b1; iwbm_dat_i = data;
        end
        if (busy_n == kill_at) if_kill_i = 1'b1;
      end
      check_eq("kill_stall", {31'b0, if_stall_o}, 32'd1);
    end
    check_eq("kill_busy_cycles", busy_n, busy_len(waits));
    check_eq("kill_inst_kept", if_instruction_o, last_inst);
    check_eq("kill_fault_kept", {31'b0, if_bus_access_fault_o}, {31'b0, last_fault});
  endtask

  task automatic reset_mid_busy(input logic [31:0] pc);
    if_pc_i = pc; iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_cyc_before", {31'b0, iwbm_cyc_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_cyc", {31'b0, iwbm_cyc_o}, 32'd0);
    check_eq("rst_mid_stb", {31'b0, iwbm_stb_o}, 32'd0);
    check_eq("rst_mid_stall", {31'b0, if_stall_o}, 32'd1);
    check_eq("rst_mid_addr", iwbm_addr_o, 32'd0);
    check_eq("rst_mid_inst", if_instruction_o, NOP);
    check_eq("rst_mid_fault", {31'b0, if_bus_access_fault_o}, 32'd0);
    last_inst = NOP; last_fault = 1'b0;
  endtask

  initial begin
    int waits, kat, hold;
    logic [31:0] pc;
    rst = 1'b1; if_pc_i = '0; if_hold_i = 1'b0; if_kill_i = 1'b0;
    iwbm_dat_i = '0; iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_stall", {31'b0, if_stall_o}, 32'd1);
    check_eq("reset_cyc", {31'b0, iwbm_cyc_o}, 32'd0);
    check_eq("reset_addr", iwbm_addr_o, 32'd0);
    check_eq("reset_inst", if_instruction_o, NOP);
    check_eq("reset_fault", {31'b0, if_bus_access_fault_o}, 32'd0);
    check_eq("sel", {28'b0, iwbm_sel_o}, 32'hF);
    check_eq("we", {31'b0, iwbm_we_o}, 32'd0);
    rst = 1'b0;
    last_inst = NOP; last_fault = 1'b0;

    fetch(32'h0000_0000, 0, 1'b0, 1'b0, 32'h0050_0093, 0, 1'b0);
    fetch(32'h0000_0100, 3, 1'b0, 1'b0, 32'hCAFE_0001, 0, 1'b0);
    fetch(32'h0000_0200, 0, 1'b1, 1'b0, 32'h1111_2222, 0, 1'b0);
    fetch(32'h0000_0300, 40, 1'b0, 1'b0, 32'h3333_4444, 0, 1'b0);
    kill_fetch(32'h0000_0380, 3, 2, 32'hDEAD_BEEF);
    fetch(32'h0000_0400, 1, 1'b0, 1'b0, 32'h1234_5678, 0, 1'b0);
    fetch(32'h0000_0500, 0, 1'b0, 1'b0, 32'h5555_AAAA, 5, 1'b0);
    fetch(32'h0000_0600, 1, 1'b0, 1'b0, 32'h6666_0000, 2, 1'b1);
    fetch(32'h0000_0102, 0, 1'b0, 1'b0, 32'h7777_7777, 1, 1'b0);
    fetch(32'h0000_0700, 2, 1'b0, 1'b1, 32'h8888_9999, 0, 1'b0);
    kill_fetch(32'h0000_0780, 0, 1, 32'hDEAD_BEEF);
    kill_fetch(32'h0000_07C0, 40, 3, 32'hDEAD_BEEF);
    fetch(32'h0000_0800, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
    reset_mid_busy(32'h0000_0900);

    for (int i = 0; i < 40; i++) begin
      pc = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      waits = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
      hold  = int'($urandom_range(0, 3));
      if (pc[1:0] == 2'b00 && $urandom_range(0, 5) == 0) begin
        kat = int'($urandom_range(1, busy_len(waits)));
        kill_fetch(pc, waits, kat, $urandom);
      end else begin
        fetch(pc, waits, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), $urandom,
              hold, ($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
